// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, shift-amount width and the
// state encoding of the iterative left shifter.
package alu_pkg;

    localparam int XLEN = 64;
    localparam int SHW  = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sll_state_t;

endpackage

// File: rtl/sll_stage.sv
// One radix-2 barrel stage: shifts acc left by 2**idx when en is set,
// otherwise passes acc through unchanged. Zero-filled from the LSB.
module sll_stage #(
    parameter int WIDTH = 64,
    parameter int IDXW  = 3
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [IDXW-1:0]  idx,
    input  logic             en,
    output logic [WIDTH-1:0] res
);

    logic [WIDTH-1:0] shifted;

    // Shift distance is a power of two selected by the stage index.
    always_comb begin
        shifted = acc << (32'd1 << idx);
        res     = en ? shifted : acc;
    end

endmodule

// File: rtl/sll_iter.sv
// Multi-cycle logical left shifter. One barrel stage is applied per clock,
// MSB stage first (32,16,8,4,2,1), so every operation takes SHW cycles
// from acceptance to out_valid regardless of the shift amount.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is only high in IDLE (and not during a flush, because a
// flushing cycle never accepts). out_valid is only high in DONE, and Result is
// held stable until out_ready is seen; Result reads 0 whenever out_valid is 0.
module sll_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::XLEN,
    parameter int SHW   = alu_pkg::SHW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   shamt,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             busy
);

    // Counter width large enough to hold SHW-1 and index sh_q.
    localparam int CW = (SHW > 1) ? $clog2(SHW) : 1;

    sll_state_t       state;
    sll_state_t       state_nxt;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   sh_q;
    logic [CW-1:0]    cnt;
    logic             alive;
    logic             accept;
    logic [WIDTH-1:0] stage_res;

    // The single barrel stage, time-multiplexed across cycles by cnt.
    sll_stage #(
        .WIDTH (WIDTH),
        .IDXW  (CW)
    ) u_stage (
        .acc (acc),
        .idx (cnt),
        .en  (sh_q[cnt]),
        .res (stage_res)
    );

    assign accept = in_valid && in_ready;

    // Keeps in_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive <= 1'b0;
        end else begin
            alive <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = SHIFT;
                SHIFT:   if (cnt == '0) state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output decode from the current state.
    always_comb begin
        in_ready  = alive && (state == IDLE) && !flush;
        out_valid = (state == DONE);
        busy      = (state == SHIFT) || (state == DONE);
        Result    = (state == DONE) ? acc : '0;
    end

    // Datapath: load on accept, apply one stage per SHIFT cycle, hold in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            sh_q <= '0;
            cnt  <= '0;
        end else if (flush) begin
            acc  <= '0;
            sh_q <= '0;
            cnt  <= '0;
        end else if (accept) begin
            acc  <= A;
            sh_q <= shamt;
            cnt  <= CW'(SHW - 1);
        end else if (state == SHIFT) begin
            acc <= stage_res;
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule
